// File: rtl/imm_extend_stage.sv
// Registered immediate extender for the decode/execute boundary.
// Elastic valid/ready stage with an optional one-entry skid register and flush.
module imm_extend_stage #(
  parameter int XLEN    = 32,  // 32 or 64
  parameter bit SKID_EN = 1'b1
) (
  input  logic            i_Clk,
  input  logic            i_Reset,
  input  logic            i_Flush,
  input  logic            i_Valid,
  output logic            o_Ready,
  input  logic [31:7]     i_Instr,
  input  logic [2:0]      i_ImmSrc,
  output logic            o_Valid,
  input  logic            i_Ready,
  output logic [XLEN-1:0] o_ImmExt,
  output logic            o_Illegal
);

  localparam bit IS_RV64 = (XLEN == 64);

  localparam logic [2:0] SRC_I  = 3'b000;
  localparam logic [2:0] SRC_S  = 3'b001;
  localparam logic [2:0] SRC_B  = 3'b010;
  localparam logic [2:0] SRC_J  = 3'b011;
  localparam logic [2:0] SRC_U  = 3'b100;
  localparam logic [2:0] SRC_Z  = 3'b101;
  localparam logic [2:0] SRC_SH = 3'b110;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic            ready_q, ready_d;
  logic [XLEN-1:0] out_imm_q, out_imm_d;
  logic            out_ill_q, out_ill_d;
  logic [XLEN-1:0] skid_imm_q, skid_imm_d;
  logic            skid_ill_q, skid_ill_d;

  logic [XLEN-1:0] new_imm;
  logic            new_ill;
  logic            shamt_hi;
  logic            in_fire;
  logic            out_fire;

  // Immediate decode of the incoming instruction.
  always_comb begin
    new_imm  = '0;
    new_ill  = 1'b0;
    shamt_hi = IS_RV64 ? i_Instr[25] : 1'b0;
    case (i_ImmSrc)
      SRC_I:   new_imm = XLEN'($signed(i_Instr[31:20]));
      SRC_S:   new_imm = XLEN'($signed({i_Instr[31:25], i_Instr[11:7]}));
      SRC_B:   new_imm = XLEN'($signed({i_Instr[31], i_Instr[7], i_Instr[30:25],
                                         i_Instr[11:8], 1'b0}));
      SRC_J:   new_imm = XLEN'($signed({i_Instr[31], i_Instr[19:12], i_Instr[20],
                                         i_Instr[30:21], 1'b0}));
      SRC_U:   new_imm = XLEN'($signed({i_Instr[31:12], 12'h000}));
      SRC_Z:   new_imm = XLEN'(i_Instr[19:15]);
      SRC_SH:  new_imm = XLEN'({shamt_hi, i_Instr[24:20]});
      default: begin
        new_imm = '0;
        new_ill = 1'b1;
      end
    endcase
  end

  assign in_fire  = i_Valid & o_Ready;
  assign out_fire = o_Valid & i_Ready;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q <= ST_EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (i_Flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (in_fire) state_d = ST_FULL;
        ST_FULL: begin
          if (!in_fire && out_fire)
            state_d = ST_EMPTY;
          else if (in_fire && !out_fire && SKID_EN)
            state_d = ST_SKID;
        end
        ST_SKID:  if (out_fire) state_d = ST_FULL;
        default:  state_d = ST_EMPTY;
      endcase
    end
    ready_d = (state_d != ST_SKID);
  end

  // Without a skid register the stage can only accept when the output drains.
  always_comb begin
    o_Valid   = (state_q != ST_EMPTY);
    o_Ready   = SKID_EN ? ready_q : (!o_Valid | i_Ready);
    o_ImmExt  = out_imm_q;
    o_Illegal = out_ill_q;
  end

  // Flushed entries keep their stale data; only the state marks them invalid.
  always_comb begin
    out_imm_d  = out_imm_q;
    out_ill_d  = out_ill_q;
    skid_imm_d = skid_imm_q;
    skid_ill_d = skid_ill_q;
    if (!i_Flush) begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            out_imm_d = new_imm;
            out_ill_d = new_ill;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            out_imm_d = new_imm;
            out_ill_d = new_ill;
          end else if (in_fire && SKID_EN) begin
            skid_imm_d = new_imm;
            skid_ill_d = new_ill;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            out_imm_d = skid_imm_q;
            out_ill_d = skid_ill_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      out_imm_q  <= '0;
      out_ill_q  <= 1'b0;
      skid_imm_q <= '0;
      skid_ill_q <= 1'b0;
    end else begin
      out_imm_q  <= out_imm_d;
      out_ill_q  <= out_ill_d;
      skid_imm_q <= skid_imm_d;
      skid_ill_q <= skid_ill_d;
    end
  end

endmodule
